// File: rtl/vid_pkg.sv
// vid_pkg: 1080p60 timing defaults, pixel colour constants and pattern-select encodings.
package vid_pkg;
  localparam int H_ACTIVE_1080 = 1920;
  localparam int H_FP_1080 = 88;
  localparam int H_SYNC_1080 = 44;
  localparam int H_BP_1080 = 148;
  localparam int V_ACTIVE_1080 = 1080;
  localparam int V_FP_1080 = 4;
  localparam int V_SYNC_1080 = 5;
  localparam int V_BP_1080 = 36;
  localparam int BOX_STEP = 4;
  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] BLACK = 24'h000000;
  localparam logic [23:0] GREY = 24'h404040;
  // Pixels are packed {red, blu, gre}; index 0 is the leftmost bar.
  localparam logic [7:0][23:0] BAR_TBL = {BLACK, 24'h00FF00, 24'hFF0000, 24'hFFFF00,
                                          24'h0000FF, 24'h00FFFF, 24'hFF00FF, WHITE};
  typedef enum logic [1:0] {PAT_BARS = 2'b00, PAT_CHECK = 2'b01, PAT_GRAD = 2'b10, PAT_BOX = 2'b11} pat_e;
endpackage

// File: rtl/vid_timing_gen.sv
// vid_timing_gen: raster counters with active/sync region and frame boundary decode.
module vid_timing_gen
  import vid_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_1080,
  parameter int H_FP = H_FP_1080,
  parameter int H_SYNC = H_SYNC_1080,
  parameter int H_BP = H_BP_1080,
  parameter int V_ACTIVE = V_ACTIVE_1080,
  parameter int V_FP = V_FP_1080,
  parameter int V_SYNC = V_SYNC_1080,
  parameter int V_BP = V_BP_1080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [11:0] hcount,
  output logic [10:0] vcount,
  output logic        active,
  output logic        hsync_on,
  output logic        vsync_on,
  output logic        first_px,
  output logic        last_px
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  logic [11:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic h_end, v_end;
  assign h_end = hcount_q == 12'(H_TOTAL - 1);
  assign v_end = vcount_q == 11'(V_TOTAL - 1);
  always_comb begin
    hcount_d = !en ? hcount_q : h_end ? '0 : hcount_q + 12'd1;
    vcount_d = !(en && h_end) ? vcount_q : v_end ? '0 : vcount_q + 11'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end
  assign hcount = hcount_q;
  assign vcount = vcount_q;
  assign active = hcount_q < 12'(H_ACTIVE) && vcount_q < 11'(V_ACTIVE);
  assign hsync_on = hcount_q >= 12'(H_ACTIVE + H_FP) && hcount_q < 12'(H_ACTIVE + H_FP + H_SYNC);
  assign vsync_on = vcount_q >= 11'(V_ACTIVE + V_FP) && vcount_q < 11'(V_ACTIVE + V_FP + V_SYNC);
  assign first_px = hcount_q == '0 && vcount_q == '0;
  assign last_px = h_end && v_end;
endmodule

// File: rtl/vid_pattern_gen.sv
// vid_pattern_gen: vid_io source producing 1080p timing with selectable test patterns.
module vid_pattern_gen
  import vid_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int H_ACTIVE = H_ACTIVE_1080,
  parameter int H_FP = H_FP_1080,
  parameter int H_SYNC = H_SYNC_1080,
  parameter int H_BP = H_BP_1080,
  parameter int V_ACTIVE = V_ACTIVE_1080,
  parameter int V_FP = V_FP_1080,
  parameter int V_SYNC = V_SYNC_1080,
  parameter int V_BP = V_BP_1080,
  parameter bit SYNC_POL = 1'b1,
  parameter int BOX_SIZE = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic [1:0]            sw,
  output logic [DATA_WIDTH-1:0] o_vid_data,
  output logic                  o_vid_hsync,
  output logic                  o_vid_vsync,
  output logic                  o_vid_VDE,
  output logic                  o_frame_start
);
  localparam logic [11:0] X_MAX = 12'(H_ACTIVE - BOX_SIZE);
  localparam logic [10:0] Y_MAX = 11'(V_ACTIVE - BOX_SIZE);
  localparam logic [11:0] BAR_W = 12'(H_ACTIVE / 8);
  logic [11:0] hcount;
  logic [10:0] vcount;
  logic active, hsync_on, vsync_on, first_px, last_px, upd, in_box;
  logic [2:0] bar_idx;
  logic [23:0] pix;
  pat_e pat_q, pat_d;
  logic [11:0] box_x_q, box_x_d;
  logic [10:0] box_y_q, box_y_d;
  logic x_neg_q, x_neg_d, y_neg_q, y_neg_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic vde_q, vde_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
  vid_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk(clk), .rst(rst), .en(i_en), .hcount(hcount), .vcount(vcount), .active(active),
    .hsync_on(hsync_on), .vsync_on(vsync_on), .first_px(first_px), .last_px(last_px)
  );
  // The box moves on the frame-start cycle and is drawn from the new position so no frame tears.
  always_comb begin
    upd = i_en && first_px;
    pat_d = i_en && last_px ? pat_e'(sw) : pat_q;
    x_neg_d = !upd ? x_neg_q : x_neg_q ? box_x_q >= 12'(BOX_STEP) : box_x_q + 12'(BOX_STEP) > X_MAX;
    y_neg_d = !upd ? y_neg_q : y_neg_q ? box_y_q >= 11'(BOX_STEP) : box_y_q + 11'(BOX_STEP) > Y_MAX;
    box_x_d = !upd ? box_x_q : x_neg_d ? box_x_q - 12'(BOX_STEP) : box_x_q + 12'(BOX_STEP);
    box_y_d = !upd ? box_y_q : y_neg_d ? box_y_q - 11'(BOX_STEP) : box_y_q + 11'(BOX_STEP);
    in_box = hcount >= box_x_d && hcount < box_x_d + 12'(BOX_SIZE) &&
             vcount >= box_y_d && vcount < box_y_d + 11'(BOX_SIZE);
    bar_idx = 3'(hcount / BAR_W);
    pix = !active ? BLACK :
          pat_q == PAT_BARS ? BAR_TBL[bar_idx] :
          pat_q == PAT_CHECK ? (hcount[6] ^ vcount[6] ? WHITE : BLACK) :
          pat_q == PAT_GRAD ? {hcount[10:3], vcount[10:3], 8'h80} :
          in_box ? WHITE : GREY;
    data_d = i_en ? DATA_WIDTH'(pix) : data_q;
    vde_d = i_en ? active : vde_q;
    hs_d = i_en ? (hsync_on ? SYNC_POL : !SYNC_POL) : hs_q;
    vs_d = i_en ? (vsync_on ? SYNC_POL : !SYNC_POL) : vs_q;
    fs_d = i_en ? first_px : fs_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q <= PAT_BARS;
      box_x_q <= '0;
      box_y_q <= '0;
      x_neg_q <= 1'b0;
      y_neg_q <= 1'b0;
      data_q <= '0;
      vde_q <= 1'b0;
      hs_q <= !SYNC_POL;
      vs_q <= !SYNC_POL;
      fs_q <= 1'b0;
    end else begin
      pat_q <= pat_d;
      box_x_q <= box_x_d;
      box_y_q <= box_y_d;
      x_neg_q <= x_neg_d;
      y_neg_q <= y_neg_d;
      data_q <= data_d;
      vde_q <= vde_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      fs_q <= fs_d;
    end
  end
  assign o_vid_data = data_q;
  assign o_vid_VDE = vde_q;
  assign o_vid_hsync = hs_q;
  assign o_vid_vsync = vs_q;
  assign o_frame_start = fs_q;
endmodule

// File: tb/tb_vid_pattern_gen.sv
// tb_vid_pattern_gen: scoreboard bench for vid_pattern_gen on a shrunken raster.
module tb_vid_pattern_gen;
  localparam int HA = 72, HF = 4, HS = 4, HB = 4;
  localparam int VA = 68, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int BOX = 64;
  localparam bit SP = 1'b1;
  typedef struct packed {
    logic [23:0] d;
    logic vde, hs, vs, fs;
  } out_t;
  logic clk = 1'b0;
  logic rst, i_en;
  logic [1:0] sw;
  logic [23:0] o_vid_data;
  logic o_vid_hsync, o_vid_vsync, o_vid_VDE, o_frame_start;
  int n_chk = 0, n_pass = 0;
  int mh, mv, mbx, mby, mdx, mdy, mframe, oh, ov, ofr;
  logic [1:0] mpat;
  out_t mexp;
  out_t sb[$];
  bit counting = 1'b0;
  int cnt_vde = 0, cnt_hs = 0, cnt_vs = 0, cnt_fs = 0;

  vid_pattern_gen #(
    .DATA_WIDTH(24), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(SP), .BOX_SIZE(BOX)
  ) dut (
    .clk(clk), .rst(rst), .i_en(i_en), .sw(sw), .o_vid_data(o_vid_data),
    .o_vid_hsync(o_vid_hsync), .o_vid_vsync(o_vid_vsync), .o_vid_VDE(o_vid_VDE),
    .o_frame_start(o_frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [23:0] ref_pix(input int h, input int v, input logic [1:0] p, input int bx, input int by);
    logic [2:0] rgb[8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
    logic [2:0] c;
    if (!(h < HA && v < VA)) return 24'h0;
    case (p)
      2'd0: begin
        c = rgb[h / (HA / 8)];
        return {c[2] ? 8'hFF : 8'h00, c[0] ? 8'hFF : 8'h00, c[1] ? 8'hFF : 8'h00};
      end
      2'd1: return ((h / 64) % 2) != ((v / 64) % 2) ? 24'hFFFFFF : 24'h000000;
      2'd2: return {8'(h / 8), 8'(v / 8), 8'h80};
      default: return (h >= bx && h < bx + BOX && v >= by && v < by + BOX) ? 24'hFFFFFF : 24'h404040;
    endcase
  endfunction

  task automatic cyc(input bit r, input bit e, input logic [1:0] s);
    out_t got, exp;
    rst = r;
    i_en = e;
    sw = s;
    if (r) begin
      mh = 0; mv = 0; mpat = 2'd0; mbx = 0; mby = 0; mdx = 4; mdy = 4;
      mframe = -1; oh = -1; ov = -1; ofr = -1;
      mexp = '{d: 24'h0, vde: 1'b0, hs: !SP, vs: !SP, fs: 1'b0};
    end else if (e) begin
      if (mh == 0 && mv == 0) begin
        if (mdx > 0 && mbx + 4 > HA - BOX) mdx = -4;
        else if (mdx < 0 && mbx - 4 < 0) mdx = 4;
        if (mdy > 0 && mby + 4 > VA - BOX) mdy = -4;
        else if (mdy < 0 && mby - 4 < 0) mdy = 4;
        mbx += mdx;
        mby += mdy;
        mframe++;
      end
      mexp.d = ref_pix(mh, mv, mpat, mbx, mby);
      mexp.vde = mh < HA && mv < VA;
      mexp.hs = (mh >= HA + HF && mh < HA + HF + HS) ? SP : !SP;
      mexp.vs = (mv >= VA + VF && mv < VA + VF + VS) ? SP : !SP;
      mexp.fs = mh == 0 && mv == 0;
      oh = mh; ov = mv; ofr = mframe;
      if (mh == HT - 1 && mv == VT - 1) mpat = s;
      mh++;
      if (mh == HT) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end
    end
    sb.push_back(mexp);
    @(posedge clk);
    #1;
    exp = sb.pop_front();
    got = {o_vid_data, o_vid_VDE, o_vid_hsync, o_vid_vsync, o_frame_start};
    chk("out", 32'(got), 32'(exp));
    if (counting && e && !r) begin
      cnt_vde += int'(o_vid_VDE);
      cnt_hs += int'(o_vid_hsync);
      cnt_vs += int'(o_vid_vsync);
      cnt_fs += int'(o_frame_start);
    end
    if (e && !r) begin
      if (ofr == 0 && ov == 0 && oh == 0) chk("bar_white", o_vid_data, 24'hFFFFFF);
      if (ofr == 0 && ov == 0 && oh == HA / 8) chk("bar_yellow", o_vid_data, 24'hFF00FF);
      if (ofr == 0 && ov == 0 && oh == HA - 1) chk("bar_black", o_vid_data, 24'h000000);
      if (ofr == 0 && ov == 0 && oh == HA + 2) chk("blank_data", o_vid_data, 24'h000000);
      if (ofr == 1 && ov == 40 && oh == 64) chk("still_bars", o_vid_data, 24'h000000);
      if (ofr == 2 && ov == 0 && oh == 64) chk("chk_64_0", o_vid_data, 24'hFFFFFF);
      if (ofr == 2 && ov == 64 && oh == 64) chk("chk_64_64", o_vid_data, 24'h000000);
      if (ofr == 3 && ov == 16 && oh == 40) chk("grad", o_vid_data, 24'h050280);
      if (ofr == 5 && ov == 0 && oh == 8) chk("box_edge_x", o_vid_data, 24'hFFFFFF);
      if (ofr == 5 && ov == 0 && oh == 7) chk("box_out_x", o_vid_data, 24'h404040);
      if (ofr == 6 && ov == 3 && oh == 4) chk("box_out_y", o_vid_data, 24'h404040);
      if (ofr == 6 && ov == 67 && oh == 67) chk("box_corner", o_vid_data, 24'hFFFFFF);
    end
  endtask

  initial begin
    rst = 1'b1;
    i_en = 1'b0;
    sw = 2'd0;
    repeat (3) cyc(1'b1, 1'b0, 2'd0);
    chk("rst_data", o_vid_data, 24'h0);
    chk("rst_vde", o_vid_VDE, 1'b0);
    chk("rst_fs", o_frame_start, 1'b0);
    chk("rst_hs", o_vid_hsync, !SP);
    chk("rst_vs", o_vid_vsync, !SP);
    counting = 1'b1;
    repeat (FT + 34 * HT) cyc(1'b0, 1'b1, 2'd0);
    repeat (FT - 34 * HT) cyc(1'b0, 1'b1, 2'd1);
    counting = 1'b0;
    chk("vde_cycles", cnt_vde, 2 * HA * VA);
    chk("hs_cycles", cnt_hs, 2 * HS * VT);
    chk("vs_cycles", cnt_vs, 2 * VS * HT);
    chk("fs_pulses", cnt_fs, 2);
    repeat (FT - 1) cyc(1'b0, 1'b1, 2'd1);
    cyc(1'b0, 1'b1, 2'd2);
    repeat (4 * FT) cyc(1'b0, 1'b1, 2'd3);
    for (int i = 0; i < 6000; i++) cyc(1'b0, i % 3 == 0, 2'(i % 4));
    for (int i = 0; i < FT && !(mh == 40 && mv == 30); i++) cyc(1'b0, 1'b1, 2'd3);
    cyc(1'b1, 1'b1, 2'd3);
    chk("mrst_data", o_vid_data, 24'h0);
    chk("mrst_vde", o_vid_VDE, 1'b0);
    chk("mrst_hs", o_vid_hsync, !SP);
    cyc(1'b0, 1'b1, 2'd3);
    chk("mrst_fs", o_frame_start, 1'b1);
    chk("mrst_first_px", o_vid_data, 24'hFFFFFF);
    repeat (FT + 10) cyc(1'b0, 1'b1, 2'd3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/vid_pattern_gen.md
# vid_pattern_gen

Source end of the vid_io pixel interface: generates 1080p60 timing (2200 × 1125 total, 1920 × 1080 active) and drives `o_vid_data`, `o_vid_hsync`, `o_vid_vsync` and `o_vid_VDE` with a selectable test pattern. It sits upstream of `colour_change`, replacing the camera path for bring-up and filter verification. It also produces a registered frame-start strobe for bench and ILA triggering.

## Interface
- `DATA_WIDTH`, 24: pixel width, packed {red, blu, gre}, 8 bits each.
- `H_ACTIVE`/`H_FP`/`H_SYNC`/`H_BP`, 1920/88/44/148: horizontal timing in pixels.
- `V_ACTIVE`/`V_FP`/`V_SYNC`/`V_BP`, 1080/4/5/36: vertical timing in lines.
- `SYNC_POL`, 1: asserted level of hsync and vsync.
- `BOX_SIZE`, 64: moving-box edge length in pixels.
- `clk` in 1: pixel clock. One clock domain only.
- `rst` in 1: reset, synchronous, active-high.
- `i_en` in 1: pixel-clock enable. While low, counters and all outputs hold their values.
- `sw` in 2: pattern select.
- `o_vid_data` out DATA_WIDTH: pixel value.
- `o_vid_hsync` out 1: horizontal sync.
- `o_vid_vsync` out 1: vertical sync.
- `o_vid_VDE` out 1: data enable, high during the active region.
- `o_frame_start` out 1: one-cycle pulse, coincident with the first active pixel (0,0).

## Operation
- Counters:
  - `hcount` runs 0..H_TOTAL-1, where H_TOTAL = sum of the four H parameters (2200). It wraps to 0.
  - `vcount` advances when `hcount` wraps. It runs 0..V_TOTAL-1 (1125) and wraps to 0.
  - Counters are 12 bits and 11 bits. Both advance only when `i_en` is high.
- Regions, decoded from the counters:
  - Active: `hcount < H_ACTIVE` AND `vcount < V_ACTIVE`.
  - hsync asserted: `hcount` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. 2008..2051.
  - vsync asserted: `vcount` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. 1084..1088.
  - Asserted level is SYNC_POL. Deasserted level is !SYNC_POL.
- Pattern select:
  - `sw` is sampled into `pat_sel` only when `hcount == H_TOTAL-1` and `vcount == V_TOTAL-1`.
  - A pattern therefore never changes mid-frame.
- Patterns, computed from the active-region counters:
  - 00, colour bars: 8 bars, each 240 px wide; bar index = `hcount / 240`. Order: white, yellow, cyan, green, magenta, red, blue, black. Full-scale components are 8'hFF; all others are 0.
  - 01, checkerboard: 64 px squares. White when `hcount[6] ^ vcount[6]`, else black.
  - 10, gradient: red = `hcount[10:3]`, blu = `vcount[10:3]`, gre = 8'h80.
  - 11, moving box: BOX_SIZE square, white on a mid-grey (8'h40 per channel) background.
    - Box position `box_x` / `box_y` updates once per frame, on the cycle that produces `o_frame_start`.
    - Each axis moves ±4 px per frame. Direction flips when the next step would exceed the active edge, so the box is clamped and never leaves the active area.
- Outside the active region, `o_vid_data` = 0.

## Timing
- Reset values:
  - Counters 0, `pat_sel` = 00, `box_x` = `box_y` = 0, box direction +/+.
  - `o_vid_data` = 0, `o_vid_VDE` = 0, `o_frame_start` = 0.
  - `o_vid_hsync` = `o_vid_vsync` = !SYNC_POL.
- Latency: all outputs are registered, one cycle after the counter state that produced them. Data, VDE, hsync and vsync stay mutually aligned.
- First output after reset release: counter state (0,0) appears on the outputs 1 enabled cycle later, with `o_vid_VDE` = 1 and `o_frame_start` = 1.
- `i_en` low: counters and all outputs hold. `o_frame_start` also holds, so it is qualified by `i_en` downstream.
- Reset asserted mid-frame: the next cycle shows reset values. Counting restarts at (0,0) with no partial line emitted.
- Simultaneous events: when `sw` changes on the final cycle of a frame, the new value applies to the very next frame.

## Structure
- Package `vid_pkg`: 1080p timing constants, the pixel colour constants (WHITE, BLACK, GREY, bar table), and pattern-select encodings.
- Sub-module `vid_timing_gen`: counters, region decode, sync generation and frame-start decode. `vid_pattern_gen` wraps it with pattern selection and the box state.

## Test plan
- Reset, then `i_en` = 1 for 2 frames: each line has 1920 VDE cycles and hsync is high exactly for 44 cycles starting 88 after VDE falls. Each frame has 1080 VDE lines and vsync is high for 5 lines. Period = 2 475 000 cycles.
- `sw` = 00: pixel 0 = FFFFFF, pixel 240 = {FF,00,FF} (yellow), pixel 1919 = 000000, and data = 0 during blanking.
- `sw` toggles 00→01 at line 500: the current frame stays bars. The next frame's pixel (64,0) = FFFFFF and pixel (64,64) = 000000.
- `sw` = 11 over 500 frames: the box top-left advances 4 px per frame, reverses at x = 1856 and y = 1016, and never goes negative.
- `i_en` pulsed 1-in-3: the output sequence equals the continuous-enable sequence with holds inserted.
- Reset asserted at (hcount 1000, vcount 700): the next cycle shows reset values, and `o_frame_start` fires 1 cycle after release.
